// File: rtl/if_fetch_queue.sv
// Instruction fetch stage with a QDEPTH-entry queue in front of ID.
// Sequential PC reads go to a 1-cycle synchronous IRAM; redirects flush the queue and squash the read in flight.
module if_fetch_queue #(
    parameter int          ADR_W    = 12,
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_start,
    input  logic [29:0]               start_adr,
    input  logic                      redir_trap,
    input  logic [29:0]               trap_vec,
    input  logic                      redir_ret,
    input  logic [29:0]               ret_adr,
    input  logic                      redir_jmp,
    input  logic [29:0]               jmp_adr,
    input  logic                      mon_read_sel,
    output logic                      imem_req,
    output logic [ADR_W-1:0]          imem_radr,
    input  logic [31:0]               imem_rdata,
    output logic                      id_valid,
    input  logic                      id_ready,
    output logic [31:0]               inst_id,
    output logic [29:0]               pc_id,
    output logic                      post_jump_cmd_cond,
    output logic [31:0]               pc_data,
    output logic [$clog2(QDEPTH):0]   q_count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH = (CW+1)'(QDEPTH);

    logic [29:0]   pc_if;
    logic [29:0]   req_pc;
    logic [29:0]   target;
    logic          post_trap;
    logic          inflight;
    logic          redir_eff;
    logic          flush;
    logic          deq;
    logic          enq;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic [31:0]   inst_q [QDEPTH];
    logic [29:0]   pc_q   [QDEPTH];

    // An xRET or jump arriving right behind a trap belongs to the trapped instruction stream.
    always_comb begin
        redir_eff = redir_trap | ((redir_ret | redir_jmp) & ~post_trap);
        if (redir_trap) begin
            target = trap_vec;
        end else if (redir_ret) begin
            target = ret_adr;
        end else begin
            target = jmp_adr;
        end
    end

    assign flush    = cpu_start | redir_eff;
    assign id_valid = (count != '0);
    assign deq      = id_valid & id_ready;
    assign enq      = inflight & ~flush;

    // Credit check counts the outstanding read so a full queue is never overrun.
    always_comb begin
        occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, deq};
        imem_req  = ~flush & ~mon_read_sel & (occupancy < DEPTH);
    end

    assign imem_radr = pc_if[ADR_W-1:0];
    assign pc_data   = {pc_if, 2'b00};
    assign q_count   = count;
    assign inst_id   = id_valid ? inst_q[rd_ptr] : NOP_INST;
    assign pc_id     = id_valid ? pc_q[rd_ptr]   : 30'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_if              <= 30'd0;
            req_pc             <= 30'd0;
            inflight           <= 1'b0;
            post_trap          <= 1'b0;
            post_jump_cmd_cond <= 1'b0;
            rd_ptr             <= '0;
            wr_ptr             <= '0;
            count              <= '0;
        end else begin
            if (cpu_start) begin
                pc_if <= start_adr;
            end else if (redir_eff) begin
                pc_if <= target;
            end else if (imem_req) begin
                pc_if <= pc_if + 30'd1;
            end

            inflight           <= imem_req;
            post_trap          <= redir_trap;
            post_jump_cmd_cond <= redir_ret | redir_jmp;
            if (imem_req) begin
                req_pc <= pc_if;
            end

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (enq) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (deq) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({enq, deq})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            inst_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]   <= req_pc;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: per-cycle vector table for start, back-pressure,
// jump flush and monitor stall, then hand-written trap priority and mid-run reset sequences.
module tb_if_fetch_queue;

    logic        clk;
    logic        rst;
    logic        cpu_start;
    logic [29:0] start_adr;
    logic        redir_trap;
    logic [29:0] trap_vec;
    logic        redir_ret;
    logic [29:0] ret_adr;
    logic        redir_jmp;
    logic [29:0] jmp_adr;
    logic        mon_read_sel;
    logic        imem_req;
    logic [11:0] imem_radr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] inst_id;
    logic [29:0] pc_id;
    logic        post_jump_cmd_cond;
    logic [31:0] pc_data;
    logic [2:0]  q_count;

    int checks = 0;
    int errors = 0;
    logic count_watch = 1'b0;

    typedef struct {
        logic        start;
        logic        jmp;
        logic        mon;
        logic        ready;
        logic [29:0] adr;
        logic        req;
        logic [11:0] radr;
        logic        valid;
        logic [29:0] pcid;
        logic [2:0]  cnt;
        logic        pjc;
    } vec_t;

    vec_t tbl [34];

    if_fetch_queue #(.ADR_W(12), .QDEPTH(4), .NOP_INST(32'h00000013)) dut (
        .clk                (clk),
        .rst                (rst),
        .cpu_start          (cpu_start),
        .start_adr          (start_adr),
        .redir_trap         (redir_trap),
        .trap_vec           (trap_vec),
        .redir_ret          (redir_ret),
        .ret_adr            (ret_adr),
        .redir_jmp          (redir_jmp),
        .jmp_adr            (jmp_adr),
        .mon_read_sel       (mon_read_sel),
        .imem_req           (imem_req),
        .imem_radr          (imem_radr),
        .imem_rdata         (imem_rdata),
        .id_valid           (id_valid),
        .id_ready           (id_ready),
        .inst_id            (inst_id),
        .pc_id              (pc_id),
        .post_jump_cmd_cond (post_jump_cmd_cond),
        .pc_data            (pc_data),
        .q_count            (q_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // IRAM model: each word holds a tag plus its own address, so data identifies the PC.
    always @(posedge clk) begin
        if (imem_req === 1'b1) begin
            imem_rdata <= {20'hA5000, imem_radr};
        end
    end

    always @(negedge clk) begin
        if (count_watch) begin
            checks++;
            if (!(q_count <= 3'd4)) begin
                errors++;
                $display("[TB] FAIL q_count_bound actual %0d required <= 4", q_count);
            end
        end
    end

    function automatic vec_t mk(input logic start, input logic jmp, input logic mon,
                                input logic ready, input logic [29:0] adr,
                                input logic req, input logic [11:0] radr,
                                input logic valid, input logic [29:0] pcid,
                                input logic [2:0] cnt, input logic pjc);
        vec_t v;
        v.start = start; v.jmp = jmp; v.mon = mon; v.ready = ready; v.adr = adr;
        v.req = req; v.radr = radr; v.valid = valid; v.pcid = pcid; v.cnt = cnt; v.pjc = pjc;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst          = 1'b0;
        cpu_start    = v.start;
        start_adr    = v.adr;
        redir_jmp    = v.jmp;
        jmp_adr      = v.adr;
        redir_trap   = 1'b0;
        redir_ret    = 1'b0;
        mon_read_sel = v.mon;
        id_ready     = v.ready;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    initial begin
        // start, jmp, mon, ready, adr | req, radr, valid, pc_id, count, pjc
        tbl[0]  = mk(1, 0, 0, 1, 30'h100, 0, 12'h001, 0, 30'h000, 3'd0, 0);
        tbl[1]  = mk(0, 0, 0, 1, 30'h000, 1, 12'h100, 0, 30'h000, 3'd0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 30'h000, 1, 12'h101, 0, 30'h000, 3'd0, 0);
        tbl[3]  = mk(0, 0, 0, 1, 30'h000, 1, 12'h102, 1, 30'h100, 3'd1, 0);
        tbl[4]  = mk(0, 0, 0, 1, 30'h000, 1, 12'h103, 1, 30'h101, 3'd1, 0);
        tbl[5]  = mk(0, 0, 0, 1, 30'h000, 1, 12'h104, 1, 30'h102, 3'd1, 0);
        tbl[6]  = mk(0, 0, 0, 0, 30'h000, 1, 12'h105, 1, 30'h103, 3'd1, 0);
        tbl[7]  = mk(0, 0, 0, 0, 30'h000, 1, 12'h106, 1, 30'h103, 3'd2, 0);
        tbl[8]  = mk(0, 0, 0, 0, 30'h000, 0, 12'h107, 1, 30'h103, 3'd3, 0);
        for (int i = 9; i <= 15; i++) begin
            tbl[i] = mk(0, 0, 0, 0, 30'h000, 0, 12'h107, 1, 30'h103, 3'd4, 0);
        end
        tbl[16] = mk(0, 0, 0, 1, 30'h000, 1, 12'h107, 1, 30'h103, 3'd4, 0);
        tbl[17] = mk(0, 0, 0, 1, 30'h000, 1, 12'h108, 1, 30'h104, 3'd3, 0);
        tbl[18] = mk(0, 0, 0, 1, 30'h000, 1, 12'h109, 1, 30'h105, 3'd3, 0);
        tbl[19] = mk(0, 0, 0, 1, 30'h000, 1, 12'h10A, 1, 30'h106, 3'd3, 0);
        tbl[20] = mk(0, 0, 0, 1, 30'h000, 1, 12'h10B, 1, 30'h107, 3'd3, 0);
        tbl[21] = mk(0, 1, 0, 1, 30'h200, 0, 12'h10C, 1, 30'h108, 3'd3, 0);
        tbl[22] = mk(0, 0, 0, 1, 30'h000, 1, 12'h200, 0, 30'h000, 3'd0, 1);
        tbl[23] = mk(0, 0, 0, 1, 30'h000, 1, 12'h201, 0, 30'h000, 3'd0, 0);
        tbl[24] = mk(0, 0, 0, 1, 30'h000, 1, 12'h202, 1, 30'h200, 3'd1, 0);
        tbl[25] = mk(0, 0, 0, 1, 30'h000, 1, 12'h203, 1, 30'h201, 3'd1, 0);
        tbl[26] = mk(0, 0, 1, 1, 30'h000, 0, 12'h204, 1, 30'h202, 3'd1, 0);
        tbl[27] = mk(0, 0, 1, 1, 30'h000, 0, 12'h204, 1, 30'h203, 3'd1, 0);
        tbl[28] = mk(0, 0, 1, 1, 30'h000, 0, 12'h204, 0, 30'h000, 3'd0, 0);
        tbl[29] = mk(0, 0, 1, 1, 30'h000, 0, 12'h204, 0, 30'h000, 3'd0, 0);
        tbl[30] = mk(0, 0, 1, 1, 30'h000, 0, 12'h204, 0, 30'h000, 3'd0, 0);
        tbl[31] = mk(0, 0, 0, 1, 30'h000, 1, 12'h204, 0, 30'h000, 3'd0, 0);
        tbl[32] = mk(0, 0, 0, 1, 30'h000, 1, 12'h205, 0, 30'h000, 3'd0, 0);
        tbl[33] = mk(0, 0, 0, 1, 30'h000, 1, 12'h206, 1, 30'h204, 3'd1, 0);

        rst = 1'b1; cpu_start = 1'b0; start_adr = '0; redir_trap = 1'b0; trap_vec = '0;
        redir_ret = 1'b0; ret_adr = '0; redir_jmp = 1'b0; jmp_adr = '0;
        mon_read_sel = 1'b0; id_ready = 1'b1;

        // Reset state, with nothing else asserted the first sequential read issues at 0.
        @(negedge clk);
        rst = 1'b0;
        count_watch = 1'b1;
        #1;
        checkOutput("rst_id_valid", 32'(id_valid), 32'd0);
        checkOutput("rst_inst_id", inst_id, 32'h00000013);
        checkOutput("rst_pc_id", 32'(pc_id), 32'd0);
        checkOutput("rst_q_count", 32'(q_count), 32'd0);
        checkOutput("rst_pc_data", pc_data, 32'd0);
        checkOutput("rst_pjc", 32'(post_jump_cmd_cond), 32'd0);
        checkOutput("rst_imem_req", 32'(imem_req), 32'd1);
        checkOutput("rst_imem_radr", 32'(imem_radr), 32'd0);

        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            applyStimulus(tbl[i]);
            #1;
            checkOutput($sformatf("v%0d_imem_req", i), 32'(imem_req), 32'(tbl[i].req));
            checkOutput($sformatf("v%0d_imem_radr", i), 32'(imem_radr), 32'(tbl[i].radr));
            checkOutput($sformatf("v%0d_id_valid", i), 32'(id_valid), 32'(tbl[i].valid));
            checkOutput($sformatf("v%0d_pc_id", i), 32'(pc_id), 32'(tbl[i].pcid));
            checkOutput($sformatf("v%0d_q_count", i), 32'(q_count), 32'(tbl[i].cnt));
            checkOutput($sformatf("v%0d_pjc", i), 32'(post_jump_cmd_cond), 32'(tbl[i].pjc));
            checkOutput($sformatf("v%0d_inst_id", i), inst_id,
                        tbl[i].valid ? {20'hA5000, tbl[i].pcid[11:0]} : 32'h00000013);
        end

        // Trap and jump together: trap wins; the xRET right after it is ignored.
        @(negedge clk);
        cpu_start = 1'b0; mon_read_sel = 1'b0; id_ready = 1'b1;
        redir_trap = 1'b1; trap_vec = 30'h40; redir_jmp = 1'b1; jmp_adr = 30'h300;
        #1;
        checkOutput("prio_p0_imem_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        redir_trap = 1'b0; redir_jmp = 1'b0; redir_ret = 1'b1; ret_adr = 30'h500;
        #1;
        checkOutput("prio_p1_pc_data", pc_data, 32'h00000100);
        checkOutput("prio_p1_imem_radr", 32'(imem_radr), 32'h040);
        checkOutput("prio_p1_imem_req", 32'(imem_req), 32'd1);
        checkOutput("prio_p1_pjc", 32'(post_jump_cmd_cond), 32'd1);
        checkOutput("prio_p1_q_count", 32'(q_count), 32'd0);
        @(negedge clk);
        redir_ret = 1'b0;
        #1;
        checkOutput("prio_p2_pjc", 32'(post_jump_cmd_cond), 32'd1);
        checkOutput("prio_p2_imem_radr", 32'(imem_radr), 32'h041);
        checkOutput("prio_p2_id_valid", 32'(id_valid), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("prio_p3_pjc", 32'(post_jump_cmd_cond), 32'd0);
        checkOutput("prio_p3_id_valid", 32'(id_valid), 32'd1);
        checkOutput("prio_p3_pc_id", 32'(pc_id), 32'h040);
        checkOutput("prio_p3_inst_id", inst_id, 32'hA5000040);

        // Reset mid-run with two entries queued and a read in flight.
        @(negedge clk);
        id_ready = 1'b0;
        #1;
        checkOutput("mrst_r0_q_count", 32'(q_count), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("mrst_r1_q_count", 32'(q_count), 32'd2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("mrst_r2_id_valid", 32'(id_valid), 32'd0);
        checkOutput("mrst_r2_inst_id", inst_id, 32'h00000013);
        checkOutput("mrst_r2_pc_data", pc_data, 32'd0);
        checkOutput("mrst_r2_q_count", 32'(q_count), 32'd0);
        checkOutput("mrst_r2_pc_id", 32'(pc_id), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("mrst_r3_q_count", 32'(q_count), 32'd0);
        checkOutput("mrst_r3_imem_radr", 32'(imem_radr), 32'h001);

        count_watch = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised successor to the single-entry instruction fetch stage.
- Issues sequential PC reads to a 1-cycle-latency synchronous instruction RAM.
- Buffers returned instructions in a QDEPTH-entry FIFO and hands them to ID over a valid/ready handshake.
- Handles prioritised redirects (trap > xRET > jump) with full flush and squash of any in-flight read; replaces the stall/roll/collision registers of the previous stage with back-pressure.

Parameters:
ADR_W, 12, IRAM word-address width (imem_radr = pc_if[ADR_W+1:2])
QDEPTH, 4, FIFO entries; power of two, >= 2
NOP_INST, 32'h00000013, value driven on inst_id while id_valid=0

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cpu_start  in  1  load start_adr, flush
start_adr  in  30  start PC [31:2]
redir_trap  in  1  ecall | interrupt | exception
trap_vec  in  30  mtvec [31:2]
redir_ret  in  1  mret | sret | uret
ret_adr  in  30  selected xEPC [31:2]
redir_jmp  in  1  taken jump/branch from EX
jmp_adr  in  30  jump target [31:2]
mon_read_sel  in  1  monitor owns IRAM read port; no issue
imem_req  out  1  read issued this cycle
imem_radr  out  ADR_W  IRAM word address
imem_rdata  in  32  data, valid the cycle after imem_req
id_valid  out  1  FIFO head valid
id_ready  in  1  ID accepts head
inst_id  out  32  head instruction
pc_id  out  30  head PC [31:2]
post_jump_cmd_cond  out  1  registered (redir_ret | redir_jmp)
pc_data  out  32  {pc_if, 2'b00}
q_count  out  $clog2(QDEPTH)+1  FIFO occupancy

Behaviour:
Reset:
- rst is synchronous and active-high; it has priority over everything else.
- rst clears pc_if, FIFO pointers/count, inflight, post_trap and post_jump_cmd_cond to 0.
- After reset: id_valid=0, inst_id=NOP_INST, pc_id=0, imem_req per the issue rule.
- rst mid-operation discards the FIFO and any in-flight read.

Redirect:
- redir_eff = redir_trap | ((redir_ret | redir_jmp) & ~post_trap).
- post_trap is redir_trap delayed one cycle; an xRET/jump in the cycle after a trap is ignored.
- Target: trap_vec if redir_trap, else ret_adr if redir_ret, else jmp_adr.

pc_if update, in priority order:
- cpu_start: pc_if <= start_adr.
- redir_eff: pc_if <= target.
- imem_req: pc_if <= pc_if + 1, wrapping modulo 2^30.
- Otherwise hold.

Flush:
- Condition: cpu_start | redir_eff.
- At the edge: FIFO emptied (pointers/count to 0).
- A read in flight that cycle is squashed: inflight is cleared and its data the next cycle is not enqueued.

Issue:
- imem_req = ~flush & ~mon_read_sel & (count + inflight - deq < QDEPTH), where deq = id_valid & id_ready.
- imem_radr = pc_if[ADR_W+1:2], driven regardless of imem_req.
- inflight <= imem_req.

Enqueue:
- Condition: inflight & ~flush.
- Writes {imem_rdata, PC of that request} at wr_ptr. The request PC is latched at issue.
- Simultaneous enqueue and dequeue leaves count unchanged.
- The credit rule guarantees no enqueue into a full FIFO; the bench asserts count <= QDEPTH.

Dequeue:
- id_valid = (count != 0).
- inst_id/pc_id show the head entry; NOP_INST/0 when empty.
- Head advances on id_valid & id_ready.
- A flush cycle with deq=1 still empties the FIFO.

Latency and throughput:
- Redirect/start sampled in cycle 0 -> issue at target in cycle 1 -> enqueue at end of cycle 2 -> id_valid in cycle 3.
- With id_ready held at 1, one instruction per cycle for any QDEPTH >= 2.

mon_read_sel:
- Blocks new issue only; an outstanding read completes and is enqueued.

Other outputs:
- post_jump_cmd_cond <= redir_ret | redir_jmp (ungated).
- pc_data is combinational from pc_if.

Test Plan:
- Start: rst 1 cycle, cpu_start with start_adr=0x100, id_ready=1 -> imem_radr 0x100,0x101,... from cycle 1; id_valid in cycle 3 with pc_id=0x100, then pc_id increments by 1 every cycle.
- Back-pressure: QDEPTH=4, id_ready=0 for 10 cycles -> q_count reaches 4 and stays; imem_req=0 while full; release -> 4 entries dequeued in order, no gap, no duplicate or lost PC.
- Jump flush: redir_jmp with jmp_adr=0x200 while q_count=3 and a read in flight -> next cycle q_count=0, stale data not enqueued; first id_valid has pc_id=0x200 three cycles later.
- Priority: redir_trap (trap_vec=0x40) with redir_jmp (0x300) in the same cycle, then redir_ret (0x500) the next cycle -> pc goes to 0x40 and the xRET is ignored; post_jump_cmd_cond=1 in the following two cycles.
- Monitor: mon_read_sel=1 for 5 cycles mid-stream -> no imem_req; the one in-flight instruction is enqueued; resume at the next sequential PC with no skip.
- Reset mid-run: rst with q_count=2 -> next cycle id_valid=0, inst_id=0x00000013, pc_data=0, q_count=0.
